// File: rtl/boot_pkg.sv
// Shared types and header-field layout for the UART bootloader protocol engine.
package boot_pkg;

  typedef enum logic [2:0] {
    HDR,
    WR,
    RD_REQ,
    RD_WAIT,
    RD_SEND
  } boot_state_t;

  localparam int HDR_OP_BIT   = 31;
  localparam int HDR_ADDR_MSB = 30;
  localparam int HDR_ADDR_LSB = 16;
  localparam int HDR_LEN_MSB  = 15;
  localparam int HDR_LEN_LSB  = 0;

  localparam int BOOT_MAX_WORDS = 65535;

  // Byte lane select of a little-endian word; lane 0 is bits [7:0].
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Little-endian byte-to-word assembler: four byte strobes build one 32-bit word.
// word/word_done present the completed word combinationally on the 4th byte.
module boot_word_asm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        word_done
);

  logic [31:0] shreg;

  // New bytes enter at the top so the first byte ends up in bits [7:0].
  assign word      = {byte_data, shreg[31:8]};
  assign word_done = byte_valid && !clr && (byte_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (byte_valid) begin
      shreg    <= word;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/uart_boot_ctrl.sv
// UART bootloader protocol engine: header decode, IMEM write stream, DMEM read-back.
// Optional inter-byte gap watchdog enabled by defining BOOT_TIMEOUT_EN.
module uart_boot_ctrl
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  dmem_re,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output boot_state_t           state_dbg
);

  // Handshake: a byte moves to the transmitter on a cycle where tx_valid && tx_ready;
  // tx_valid and tx_data stay constant until then. rx_valid is a one-cycle strobe.

  boot_state_t           state, state_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           cnt;
  logic [1:0]            byte_idx;
  logic [31:0]           rd_word;

  logic        asm_clr, asm_valid, asm_done;
  logic [31:0] asm_word;
  logic [1:0]  asm_cnt;
  logic        rd_state, tx_acc, timeout_hit;
  logic        hdr_op;
  logic [15:0] hdr_len;

  assign rd_state  = (state == RD_REQ) || (state == RD_WAIT) || (state == RD_SEND);
  assign asm_valid = rx_valid && !rd_state;
  assign asm_clr   = rd_state || timeout_hit;
  assign hdr_op    = asm_word[HDR_OP_BIT];
  assign hdr_len   = asm_word[HDR_LEN_MSB:HDR_LEN_LSB];

  boot_word_asm u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (asm_clr),
    .byte_valid (asm_valid),
    .byte_data  (rx_data),
    .word       (asm_word),
    .byte_cnt   (asm_cnt),
    .word_done  (asm_done)
  );

  assign tx_valid  = (state == RD_SEND);
  assign tx_data   = word_byte(rd_word, byte_idx);
  assign tx_acc    = tx_valid && tx_ready;
  assign dmem_re   = (state == RD_REQ);
  assign dmem_addr = addr;
  assign busy      = (state != HDR);
  assign state_dbg = state;

`ifdef BOOT_TIMEOUT_EN
  logic [31:0] gap_cnt;
  logic        gap_run;

  assign gap_run     = (asm_cnt != 2'd0) || (state != HDR);
  // Activity this cycle always wins, so a timeout never collides with a word completion.
  assign timeout_hit = gap_run && !rx_valid && !tx_acc &&
                       (gap_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (rx_valid || tx_acc || !gap_run || timeout_hit) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HDR;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HDR: begin
        if (asm_done && (hdr_len != 16'd0)) state_next = hdr_op ? WR : RD_REQ;
      end
      WR: begin
        if (asm_done && (cnt == 16'd1)) state_next = HDR;
      end
      RD_REQ:  state_next = RD_WAIT;
      RD_WAIT: state_next = RD_SEND;
      RD_SEND: begin
        if (tx_acc && (byte_idx == 2'd3)) state_next = (cnt == 16'd1) ? HDR : RD_REQ;
      end
      default: state_next = HDR;
    endcase
    if (timeout_hit) state_next = HDR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      cnt        <= '0;
      byte_idx   <= '0;
      rd_word    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        HDR: begin
          if (asm_done) begin
            addr <= asm_word[HDR_ADDR_LSB +: ADDR_WIDTH];
            cnt  <= hdr_len;
          end
        end
        WR: begin
          if (asm_done) begin
            imem_we    <= 1'b1;
            imem_addr  <= addr;
            imem_wdata <= asm_word;
            addr       <= addr + 1'b1;
            cnt        <= cnt - 16'd1;
          end
        end
        RD_WAIT: begin
          rd_word  <= dmem_rdata;
          byte_idx <= 2'd0;
        end
        RD_SEND: begin
          if (tx_acc) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              addr <= addr + 1'b1;
              cnt  <= cnt - 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Hold rises on the first header byte; an empty header or the end of a transfer releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_hold <= 1'b0;
    end else if (timeout_hit) begin
      cpu_hold <= 1'b0;
    end else if ((state == HDR) && asm_valid) begin
      cpu_hold <= !(asm_done && (hdr_len == 16'd0));
    end else if ((state != HDR) && (state_next == HDR)) begin
      cpu_hold <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Self-checking bench for uart_boot_ctrl: scoreboards for IMEM writes and tx bytes.
module tb_uart_boot_ctrl;
  import boot_pkg::*;

  localparam int AW = 11;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          dmem_re;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_rdata = '0;
  logic          cpu_hold;
  logic          busy;
  boot_state_t   state_dbg;

  uart_boot_ctrl #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .dmem_re    (dmem_re),
    .dmem_addr  (dmem_addr),
    .dmem_rdata (dmem_rdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  logic [31:0] dmem_mem [0:2047];
  always @(posedge clk) if (dmem_re) dmem_rdata <= dmem_mem[dmem_addr];

  // Scoreboard
  int errors = 0;
  int checks = 0;
  logic [AW+31:0] exp_wr_q[$];
  logic [7:0]     exp_tx_q[$];
  logic [AW+31:0] wr_exp;
  logic [7:0]     tx_exp;

  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL imem_unexpected: got addr=%0d data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        wr_exp = exp_wr_q.pop_front();
        if ({imem_addr, imem_wdata} !== wr_exp) begin
          errors++;
          $display("FAIL imem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   imem_addr, imem_wdata, wr_exp[AW+31:32], wr_exp[31:0]);
        end
      end
    end
    if (rst_n && tx_valid && tx_ready) begin
      checks++;
      if (exp_tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got byte %h, expected none", tx_data);
      end else begin
        tx_exp = exp_tx_q.pop_front();
        if (tx_data !== tx_exp) begin
          errors++;
          $display("FAIL tx_byte: got %h, expected %h", tx_data, tx_exp);
        end
      end
    end
  end

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
    exp_wr_q.push_back({a, d});
  endtask

  task automatic push_tx_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_tx_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((exp_wr_q.size() != 0 || exp_tx_q.size() != 0) && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_wr_q.size() != 0 || exp_tx_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d writes and %0d bytes outstanding, expected 0 and 0",
               exp_wr_q.size(), exp_tx_q.size());
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (busy !== 1'b0 || cpu_hold !== 1'b0 || state_dbg !== HDR) begin
      errors++;
      $display("FAIL %s: busy=%b cpu_hold=%b state=%0d, expected busy=0 cpu_hold=0 state=HDR",
               name, busy, cpu_hold, state_dbg);
    end
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({imem_we, dmem_re, tx_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: we/re/tx_valid=%b, expected 000", {imem_we, dmem_re, tx_valid});
    end
    check_idle("reset_state");
    checks++;
    if (imem_addr !== '0 || imem_wdata !== '0 || dmem_addr !== '0) begin
      errors++;
      $display("FAIL reset_data: imem_addr=%0d imem_wdata=%h dmem_addr=%0d, expected all 0",
               imem_addr, imem_wdata, dmem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    push_wr(11'd0, 32'h0000_0013);
    push_wr(11'd1, 32'hDEAD_BEEF);
    send_word(32'h8000_0002);
    checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL write_hdr: busy=%b cpu_hold=%b, expected 1 1", busy, cpu_hold);
    end
    send_word(32'h0000_0013);
    checks++;
    if (imem_we !== 1'b1) begin
      errors++;
      $display("FAIL write_latency: imem_we=%b after 4th byte, expected 1", imem_we);
    end
    send_word(32'hDEAD_BEEF);
    checks++;
    if (imem_we !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL write_end: we=%b busy=%b hold=%b, expected 1 0 0", imem_we, busy, cpu_hold);
    end
    wait_drain(20);
  endtask

  task automatic test_read();
    dmem_mem[0] = 32'h1122_3344;
    dmem_mem[1] = 32'hA5A5_A5A5;
    tx_ready = 1'b1;
    push_tx_word(32'h1122_3344);
    push_tx_word(32'hA5A5_A5A5);
    send_word(32'h0000_0002);
    checks++;
    if (dmem_re !== 1'b1 || dmem_addr !== 11'd0) begin
      errors++;
      $display("FAIL read_req: dmem_re=%b addr=%0d, expected 1 0", dmem_re, dmem_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (tx_valid !== 1'b0 || dmem_re !== 1'b0) begin
      errors++;
      $display("FAIL read_wait: tx_valid=%b dmem_re=%b, expected 0 0", tx_valid, dmem_re);
    end
    @(posedge clk); #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h44) begin
      errors++;
      $display("FAIL read_first: tx_valid=%b tx_data=%h, expected 1 44", tx_valid, tx_data);
    end
    wait_drain(60);
    check_idle("read_end");
  endtask

  task automatic test_backpressure();
    logic stable;
    int   n;
    dmem_mem[5] = 32'hCAFE_F00D;
    tx_ready = 1'b0;
    push_tx_word(32'hCAFE_F00D);
    send_word(32'h0005_0001);
    n = 0;
    while (tx_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (tx_valid !== 1'b1 || tx_data !== 8'h0D) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_hold: tx_valid=%b tx_data=%h, expected held 1 0d", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    wait_drain(30);
    check_idle("backpressure_end");
  endtask

  task automatic test_zero_len();
    send_word(32'h8005_0000);
    repeat (3) @(posedge clk);
    #1;
    check_idle("zero_len_idle");
    push_wr(11'd0, 32'h1234_5678);
    send_word(32'h8000_0001);
    send_word(32'h1234_5678);
    wait_drain(20);
  endtask

  task automatic test_wrap();
    push_wr(11'd2047, 32'hAAAA_0001);
    push_wr(11'd0,    32'hBBBB_0002);
    send_word(32'h87FF_0002);
    send_word(32'hAAAA_0001);
    send_word(32'hBBBB_0002);
    wait_drain(20);
    check_idle("wrap_end");
  endtask

  task automatic test_back_to_back();
    push_wr(11'd1, 32'h0BAD_F00D);
    push_wr(11'd3, 32'h600D_CAFE);
    send_word(32'h8001_0001);
    send_byte(8'h0D);
    send_byte(8'hF0);
    send_byte(8'hAD);
    @(posedge clk); #1;
    rx_data  = 8'h0B;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_data = 8'h01;
    checks++;
    if (imem_we !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final_we: we=%b busy=%b, expected 1 0", imem_we, busy);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    checks++;
    if (cpu_hold !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hdr_byte: hold=%b busy=%b, expected 1 0", cpu_hold, busy);
    end
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h80);
    checks++;
    if (busy !== 1'b1 || state_dbg !== WR) begin
      errors++;
      $display("FAIL b2b_hdr: busy=%b state=%0d, expected 1 WR", busy, state_dbg);
    end
    send_word(32'h600D_CAFE);
    wait_drain(20);
  endtask

  task automatic test_reset_mid();
    send_word(32'h8000_0003);
    send_byte(8'h11);
    send_byte(8'h22);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle("reset_mid_state");
    checks++;
    if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: we=%b addr=%0d data=%h, expected 0 0 0",
               imem_we, imem_addr, imem_wdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_wr(11'd2, 32'h0102_0304);
    send_word(32'h8002_0001);
    send_word(32'h0102_0304);
    wait_drain(20);
  endtask

`ifdef BOOT_TIMEOUT_EN
  task automatic test_timeout();
    send_word(32'h8000_0002);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    repeat (105) @(posedge clk);
    #1;
    check_idle("timeout_idle");
    push_wr(11'd0, 32'h0000_0055);
    send_word(32'h8000_0001);
    send_word(32'h0000_0055);
    wait_drain(20);
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) dmem_mem[i] = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef BOOT_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (exp_wr_q.size() != 0 || exp_tx_q.size() != 0) begin
      errors++;
      $display("FAIL final_queues: %0d writes %0d bytes left, expected 0 0", exp_wr_q.size(), exp_tx_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
